// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide unit and controller. It owns HI/LO and
// raises busy plus the D-stage stall while an operation is in flight.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   md_op[2:0]        E-stage op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                     5 MTHI, 6 MTLO, 7 none
//   flush             E-stage instruction cancelled this cycle
//   rs_data, rt_data  forwarded E-stage operands
//   d_is_md           D-stage instruction uses the MDU
//   start             mult/div accepted this cycle (combinational)
//   busy              operation in flight (registered)
//   stall             hold the D-stage MDU instruction (combinational)
//   hi_out, lo_out    HI/LO registers
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic        flush,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        d_is_md,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_we;

  logic is_mult;
  logic is_multu;
  logic is_div;
  logic is_divu;
  logic is_mthi;
  logic is_mtlo;

  always_comb begin
    is_mult  = 1'b0;
    is_multu = 1'b0;
    is_div   = 1'b0;
    is_divu  = 1'b0;
    is_mthi  = 1'b0;
    is_mtlo  = 1'b0;
    case (md_op)
      3'd1:    is_mult  = 1'b1;
      3'd2:    is_multu = 1'b1;
      3'd3:    is_div   = 1'b1;
      3'd4:    is_divu  = 1'b1;
      3'd5:    is_mthi  = 1'b1;
      3'd6:    is_mtlo  = 1'b1;
      default: ;
    endcase
  end

  logic any_mul;
  logic any_div;
  logic idle_ok;

  assign any_mul = is_mult | is_multu;
  assign any_div = is_div | is_divu;
  assign idle_ok = (state == IDLE) & ~flush;
  assign start   = idle_ok & (any_mul | any_div);
  assign stall   = d_is_md & (start | busy);

  // Low 64 bits of a product of sign-extended operands equal the
  // signed 32x32 product, so one unsigned multiplier form serves both.
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = {{32{rs_data[31]}}, rs_data} *
                  {{32{rt_data[31]}}, rt_data};
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // Divide on magnitudes, then restore signs. The magnitude of
  // 0x80000000 is itself as unsigned, which yields the wrapped
  // quotient 0x80000000 for 0x80000000 / -1 with no special case.
  logic        a_neg;
  logic        b_neg;
  logic        div_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_res;
  logic [31:0] r_res;

  assign a_neg    = is_div & rs_data[31];
  assign b_neg    = is_div & rt_data[31];
  assign div_zero = (rt_data == 32'd0);
  assign a_mag    = a_neg ? -rs_data : rs_data;
  assign b_mag    = b_neg ? -rt_data : rt_data;
  // Keep the divider X-free on a zero divisor; the result is dropped.
  assign b_safe   = div_zero ? 32'd1 : b_mag;
  assign q_mag    = a_mag / b_safe;
  assign r_mag    = a_mag % b_safe;
  assign q_res    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign r_res    = a_neg ? -r_mag : r_mag;

  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    res_hi = r_res;
    res_lo = q_res;
    if (is_mult) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (is_multu) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= BUSY;
            busy    <= 1'b1;
            cnt     <= any_div ? CW'(DIV_CYCLES)
                               : CW'(MULT_CYCLES);
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_we <= ~(any_div & div_zero);
          end else if (idle_ok & is_mthi) begin
            hi <= rs_data;
          end else if (idle_ok & is_mtlo) begin
            lo <= rs_data;
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (pend_we) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign hi_out = hi;
  assign lo_out = lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and random checks of mdu_ctrl against a
// cycle-indexed transaction model of HI/LO and the busy window.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic        flush;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        d_is_md;
  logic        start;
  logic        busy;
  logic        stall;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_chk  = 0;
  int n_fail = 0;

  mdu_ctrl #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .md_op  (md_op),
    .flush  (flush),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .d_is_md(d_is_md),
    .start  (start),
    .busy   (busy),
    .stall  (stall),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  // Model: architectural HI/LO, a pending result, and the cycle index
  // at which the in-flight operation retires.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_we, p_act;
  int          cyc, end_cyc;

  function automatic bit m_busy();
    return cyc < end_cyc;
  endfunction

  function automatic void model_reset();
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0;
    p_we = 0; p_act = 0; cyc = 0; end_cyc = 0;
  endfunction

  function automatic void model_op(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] h,
    output logic [31:0] l,
    output bit          we
  );
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a; sb = b; we = 1; h = 0; l = 0;
    case (op)
      3'd1: begin
        sp = longint'(sa) * longint'(sb);
        h = sp[63:32]; l = sp[31:0];
      end
      3'd2: begin
        up = {32'd0, a} * {32'd0, b};
        h = up[63:32]; l = up[31:0];
      end
      3'd3: begin
        if (b == 0) we = 0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 0;
        end else begin
          l = sa / sb; h = sa % sb;
        end
      end
      3'd4: begin
        if (b == 0) we = 0;
        else begin l = a / b; h = a % b; end
      end
      default: we = 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic es, est;
    if (!reset) begin
      es  = !m_busy() && !flush && (md_op inside {[3'd1:3'd4]});
      est = d_is_md && (es || m_busy());
      chk("start", 32'(start), 32'(es));
      chk("busy",  32'(busy),  32'(m_busy()));
      chk("stall", 32'(stall), 32'(est));
      chk("hi",    hi_out, m_hi);
      chk("lo",    lo_out, m_lo);
    end
  end

  task automatic drive(input logic [2:0] op, input bit fl,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit dmd);
    md_op = op; flush = fl; rs_data = a; rt_data = b; d_is_md = dmd;
  endtask

  // Advance one clock edge, updating the model from the inputs
  // presented during the cycle that just ended.
  task automatic tick();
    bit          go, mt, we;
    logic [31:0] h, l;
    logic [2:0]  op;
    logic [31:0] a;
    go = !m_busy() && !flush && (md_op inside {[3'd1:3'd4]});
    mt = !m_busy() && !flush;
    op = md_op; a = rs_data;
    h = 0; l = 0; we = 0;
    if (go) model_op(md_op, rs_data, rt_data, h, l, we);
    @(posedge clk);
    cyc++;
    if (p_act && cyc == end_cyc) begin
      if (p_we) begin m_hi = p_hi; m_lo = p_lo; end
      p_act = 0;
    end
    if (go) begin
      p_hi = h; p_lo = l; p_we = we; p_act = 1;
      end_cyc = cyc + ((op >= 3'd3) ? DC : MC);
    end else if (mt && op == 3'd5) m_hi = a;
    else if (mt && op == 3'd6) m_lo = a;
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit fl0,
                        input bit fl1, input bit dmd,
                        output int nb, output int ns);
    nb = 0; ns = 0;
    drive(op, fl0, a, b, dmd);
    #3; nb += int'(busy); ns += int'(stall);
    tick();
    for (int i = 0; i < 15; i++) begin
      drive(3'd0, (i == 0) ? fl1 : 1'b0, $urandom, $urandom, dmd);
      #3; nb += int'(busy); ns += int'(stall);
      tick();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  int nb, ns;

  initial begin
    model_reset();
    reset = 1'b1;
    drive(3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    #12;
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, nb, ns);
    chk("mult_nbusy", 32'(nb), 32'd5);
    chk("mult_nstall", 32'(ns), 32'd0);
    chk("mult_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", lo_out, 32'hFFFF_FFFA);
    chk("model_mult_hi", m_hi, 32'hFFFF_FFFF);

    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, nb, ns);
    chk("multu_hi", hi_out, 32'h0000_0002);
    chk("multu_lo", lo_out, 32'hFFFF_FFFA);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, nb, ns);
    chk("div_nbusy", 32'(nb), 32'd10);
    chk("div_nstall", 32'(ns), 32'd11);
    chk("div_lo", lo_out, 32'hFFFF_FFFD);
    chk("div_hi", hi_out, 32'hFFFF_FFFF);
    chk("model_div_lo", m_lo, 32'hFFFF_FFFD);

    run_op(3'd4, 32'd7, 32'd2, 0, 0, 0, nb, ns);
    chk("divu_lo", lo_out, 32'd3);
    chk("divu_hi", hi_out, 32'd1);

    drive(3'd5, 1'b0, 32'h1234_5678, 32'd0, 1'b0);
    tick();
    chk("mthi", hi_out, 32'h1234_5678);
    run_op(3'd3, 32'd99, 32'd0, 0, 0, 0, nb, ns);
    chk("div0_nbusy", 32'(nb), 32'd10);
    chk("div0_hi", hi_out, 32'h1234_5678);
    chk("div0_lo", lo_out, 32'd3);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, nb, ns);
    chk("ovf_lo", lo_out, 32'h8000_0000);
    chk("ovf_hi", hi_out, 32'd0);

    run_op(3'd1, 32'd5, 32'd5, 1, 0, 1, nb, ns);
    chk("flush_nbusy", 32'(nb), 32'd0);
    chk("flush_lo", lo_out, 32'h8000_0000);

    run_op(3'd1, 32'hFFFF_FFFA, 32'd7, 0, 1, 0, nb, ns);
    chk("lateflush_nbusy", 32'(nb), 32'd5);
    chk("lateflush_hi", hi_out, 32'hFFFF_FFFF);
    chk("lateflush_lo", lo_out, 32'hFFFF_FFD6);

    drive(3'd3, 1'b0, 32'd1000, 32'd3, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi_out, 32'd0);
    chk("arst_lo", lo_out, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(3'd1, 32'd3, 32'd4, 0, 0, 0, nb, ns);
    chk("post_rst_lo", lo_out, 32'd12);
    chk("post_rst_hi", hi_out, 32'd0);

    for (int i = 0; i < 600; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (m_busy()) op = 3'd0;
      drive(op, ($urandom_range(0, 7) == 0), pick(), pick(),
            1'($urandom_range(0, 1)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
